// File: rtl/rgb_frame_ctrl.sv
// rgb_frame_ctrl: debounced colour-select button; the captured switch colour is committed on the vsync falling edge.
// Optional auto-cycle on a committed black colour is built when RGB_AUTO_CYCLE_EN is defined.
module rgb_frame_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_FRAMES     = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sw1,
   input  logic       sw2,
   input  logic       sw3,
   input  logic       btn,
   input  logic       vsync,
   output logic [2:0] color,
   output logic       pending
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   logic             btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
   logic [2:0]       sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
   logic             vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d, vs_dly_q, vs_dly_d;
   logic             frame_q, frame_d;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       pend_col_q, pend_col_d;
   logic             pending_q, pending_d;
   logic [2:0]       color_q, color_d;
   logic             press_s;

`ifdef RGB_AUTO_CYCLE_EN
   localparam int FCNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(AUTO_FRAMES - 1);
   logic              auto_q, auto_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
`endif

   // Input synchronizers and registered vsync falling-edge strobe
   always_comb begin
      btn_meta_d = btn;
      btn_sync_d = btn_meta_q;
      sw_meta_d  = {sw1, sw2, sw3};
      sw_sync_d  = sw_meta_q;
      vs_meta_d  = vsync;
      vs_sync_d  = vs_meta_q;
      vs_dly_d   = vs_sync_q;
      frame_d    = vs_dly_q & ~vs_sync_q;
   end

   // Button debounce FSM; press_s pulses once per accepted press
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_s = 1'b0;
      case (state_q)
         RELEASED: begin
            if (btn_sync_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end else begin
               state_d = RELEASED;
            end
         end
         PRESS_WAIT: begin
            if (!btn_sync_q) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               press_s = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_sync_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else begin
               state_d = PRESSED;
            end
         end
         RELEASE_WAIT: begin
            if (btn_sync_q) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Pending capture and frame-boundary commit; a same-cycle press re-arms pending after the commit
   always_comb begin
      pend_col_d = pend_col_q;
      pending_d  = pending_q;
      color_d    = color_q;
      if (press_s) begin
         pend_col_d = sw_sync_q;
         pending_d  = 1'b1;
      end else if (frame_q && pending_q) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
`ifdef RGB_AUTO_CYCLE_EN
      auto_d = auto_q;
      fcnt_d = fcnt_q;
      if (frame_q && pending_q) begin
         color_d = pend_col_q;
         auto_d  = (pend_col_q == 3'b000);
         fcnt_d  = '0;
      end else if (frame_q && auto_q) begin
         if (fcnt_q == FCNT_MAX) begin
            fcnt_d  = '0;
            color_d = (color_q == 3'b111) ? 3'b001 : (color_q + 3'd1);
         end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
         end
      end else begin
         color_d = color_q;
      end
`else
      if (frame_q && pending_q) begin
         color_d = pend_col_q;
      end else begin
         color_d = color_q;
      end
`endif
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         sw_meta_q  <= 3'b000;
         sw_sync_q  <= 3'b000;
         vs_meta_q  <= 1'b1;
         vs_sync_q  <= 1'b1;
         vs_dly_q   <= 1'b1;
         frame_q    <= 1'b0;
         state_q    <= RELEASED;
         cnt_q      <= '0;
         pend_col_q <= 3'b111;
         pending_q  <= 1'b0;
         color_q    <= 3'b111;
`ifdef RGB_AUTO_CYCLE_EN
         auto_q     <= 1'b0;
         fcnt_q     <= '0;
`endif
      end else begin
         btn_meta_q <= btn_meta_d;
         btn_sync_q <= btn_sync_d;
         sw_meta_q  <= sw_meta_d;
         sw_sync_q  <= sw_sync_d;
         vs_meta_q  <= vs_meta_d;
         vs_sync_q  <= vs_sync_d;
         vs_dly_q   <= vs_dly_d;
         frame_q    <= frame_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_col_q <= pend_col_d;
         pending_q  <= pending_d;
         color_q    <= color_d;
`ifdef RGB_AUTO_CYCLE_EN
         auto_q     <= auto_d;
         fcnt_q     <= fcnt_d;
`endif
      end
   end

   assign color   = color_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_rgb_frame_ctrl.sv
// Directed bench for rgb_frame_ctrl with DEBOUNCE_CYCLES = 4 and AUTO_FRAMES = 2.
// The auto-cycle section is compiled only when RGB_AUTO_CYCLE_EN is defined.
module tb_rgb_frame_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       sw1, sw2, sw3, btn, vsync;
   logic [2:0] color;
   logic       pending;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   rgb_frame_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .AUTO_FRAMES    (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sw1    (sw1),
      .sw2    (sw2),
      .sw3    (sw3),
      .btn    (btn),
      .vsync  (vsync),
      .color  (color),
      .pending(pending)
   );

   always #5 clk = ~clk;

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_sw(input logic [2:0] v);
      {sw1, sw2, sw3} = v;
   endtask

   // Full debounced press with sw already synchronized; leaves the button released and settled
   task automatic press(input logic [2:0] v);
      set_sw(v);
      step(3);
      btn = 1'b1;
      step(8);
      btn = 1'b0;
      step(8);
   endtask

   task automatic frame();
      vsync = 1'b0;
      step(4);
      vsync = 1'b1;
      step(4);
   endtask

   initial begin
      reset = 1'b1;
      btn   = 1'b0;
      vsync = 1'b1;
      set_sw(3'b000);
      step(1);
      check_val("rst_color", {5'd0, color}, 8'h07);
      check_val("rst_pending", {7'd0, pending}, 8'h00);

      btn = 1'b1;
      step(8);
      check_val("rst_btn_held", {7'd0, pending}, 8'h00);
      btn   = 1'b0;
      reset = 1'b0;
      step(4);

      // Short glitch: three sampled-high cycles never reach the debounce count
      set_sw(3'b100);
      step(3);
      btn = 1'b1;
      step(3);
      btn = 1'b0;
      step(10);
      check_val("glitch_pending", {7'd0, pending}, 8'h00);

      // Held press: event lands on the 7th edge (k+6) counting the first sampling edge as k
      btn = 1'b1;
      step(6);
      check_val("press_k5_pending", {7'd0, pending}, 8'h00);
      step(1);
      check_val("press_k6_pending", {7'd0, pending}, 8'h01);
      step(3);
      btn = 1'b0;
      step(10);
      check_val("hold_color", {5'd0, color}, 8'h07);
      check_val("hold_pending", {7'd0, pending}, 8'h01);

      // vsync falling: color changes on edge k+3
      vsync = 1'b0;
      step(3);
      check_val("vs_k2_color", {5'd0, color}, 8'h07);
      step(1);
      check_val("vs_k3_color", {5'd0, color}, 8'h04);
      check_val("vs_k3_pending", {7'd0, pending}, 8'h00);
      vsync = 1'b1;
      step(5);

      // Two presses before one frame: latest wins
      press(3'b010);
      press(3'b001);
      check_val("two_pending", {7'd0, pending}, 8'h01);
      check_val("two_color_pre", {5'd0, color}, 8'h04);
      frame();
      check_val("two_color", {5'd0, color}, 8'h01);
      check_val("two_pending_clr", {7'd0, pending}, 8'h00);
      frame();
      check_val("idle_frame_color", {5'd0, color}, 8'h01);

      // Press event on the same edge as the commit
      press(3'b110);
      set_sw(3'b011);
      step(3);
      btn = 1'b1;
      step(3);
      vsync = 1'b0;
      step(4);
      check_val("coin_color", {5'd0, color}, 8'h06);
      check_val("coin_pending", {7'd0, pending}, 8'h01);
      vsync = 1'b1;
      btn   = 1'b0;
      set_sw(3'b111);
      step(10);
      check_val("coin_hold_color", {5'd0, color}, 8'h06);
      frame();
      check_val("coin_next_color", {5'd0, color}, 8'h03);
      check_val("coin_next_pending", {7'd0, pending}, 8'h00);

      // Reset with a pending colour discards it
      press(3'b101);
      check_val("rp_pending_set", {7'd0, pending}, 8'h01);
      reset = 1'b1;
      step(1);
      check_val("rp_pending", {7'd0, pending}, 8'h00);
      check_val("rp_color", {5'd0, color}, 8'h07);
      reset = 1'b0;
      step(2);
      frame();
      check_val("rp_frame_color", {5'd0, color}, 8'h07);

`ifdef RGB_AUTO_CYCLE_EN
      press(3'b000);
      frame();
      check_val("auto_black", {5'd0, color}, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         frame();
         frame();
         check_val("auto_step", {5'd0, color}, (i == 8) ? 8'h01 : 8'(i));
      end
      press(3'b011);
      frame();
      check_val("auto_stop", {5'd0, color}, 8'h03);
      frame();
      frame();
      check_val("auto_stopped", {5'd0, color}, 8'h03);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/rgb_frame_ctrl.md
# rgb_frame_ctrl

Controller between the switch/button colour input and the text ROM colour port of the VGA display path. Debounces the colour-select button, captures the switch-selected 3-bit colour as a pending request, and commits it to the display only at a frame boundary (vsync falling edge), so a colour change never tears mid-frame. Drives the colour input of the character ROM stage and is clocked by the same clock as the sync generator.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required on synchronized `btn` to accept a press or release (10 ms at 50 MHz)
- AUTO_FRAMES, 60, frames per auto-cycle step; used only with RGB_AUTO_CYCLE_EN
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sw1  in  1  colour bit R (raw switch)
- sw2  in  1  colour bit G (raw switch)
- sw3  in  1  colour bit B (raw switch)
- btn  in  1  raw push-button, high = pressed
- vsync  in  1  vertical sync from sync generator, active-low pulse
- color  out  3  committed colour {R,G,B} to the ROM stage
- pending  out  1  a captured colour awaits the next frame boundary

## Operation
- Reset: color = 3'b111, pending = 0, pending colour register = 3'b111, button FSM = RELEASED, debounce counter = 0, synchronizers cleared (vsync synchronizer cleared to 1).
- btn, sw1..sw3 and vsync each pass through a 2-FF synchronizer before use.
- Button FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: sync btn = 1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: btn = 0 -> RELEASED; counter reaches DEBOUNCE_CYCLES-1 with btn = 1 -> PRESSED, emits one-cycle press event.
  - PRESSED: btn = 0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: btn = 1 -> PRESSED; counter reaches DEBOUNCE_CYCLES-1 with btn = 0 -> RELEASED.
- Holding the button yields exactly one press event; glitches shorter than DEBOUNCE_CYCLES yield none.
- Press event: pending colour <= synchronized {sw1,sw2,sw3}; pending <= 1. A second press while pending overwrites the pending colour (latest wins).
- Frame boundary = synchronized vsync 1 -> 0 transition. If pending = 1: color <= pending colour, pending <= 0. If pending = 0: color holds (except auto-cycle, below).
- Press event and frame boundary in the same cycle: commit uses the old pending colour; the new capture sets pending = 1 and waits for the following frame.
- Debounce counter width = clog2(DEBOUNCE_CYCLES); it saturates, never wraps.
- reset mid-debounce or with pending set: all state returns to reset values on that edge; no commit occurs.

## Timing
- Raw btn rising sampled at edge k, held stable: press event at edge k+2+DEBOUNCE_CYCLES; pending rises on that edge.
- Raw vsync falling sampled at edge k: color updates at edge k+3 (2 sync + 1 edge detect).
- pending falls on the same edge color updates.
- Switch value used is the synchronized value at the press-event edge; switch changes after that edge do not affect the pending colour.
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- RGB_AUTO_CYCLE_EN defined: a committed colour of 3'b000 enables auto-cycle mode; a frame counter counts frame boundaries, and every AUTO_FRAMES-th boundary with pending = 0 increments color modulo 8, skipping 3'b000 (7 -> 1). Any commit resets the frame counter; committing a non-zero colour leaves auto-cycle mode. A pending commit always takes priority over an auto step on the same boundary.
- Not defined: 3'b000 is plain black, no frame counter is synthesized, color changes only through commits.

## Test plan
- Reset: assert reset 1 cycle -> color = 3'b111, pending = 0 on the next edge; held with btn = 1 -> no press event.
- DEBOUNCE_CYCLES = 4: sw = 3'b100, btn high 3 cycles then low -> no pending; btn high 10 cycles -> pending = 1 exactly 6 cycles after first sampled high, color still 3'b111 until vsync falls, then color = 3'b100 3 cycles after vsync falls, pending = 0.
- Two presses (sw = 3'b010 then 3'b001) before one vsync falling edge -> color = 3'b001, single commit.
- Press event coincident with vsync edge while pending holds 3'b110, new sw = 3'b011 -> color = 3'b110 that frame, pending stays 1, color = 3'b011 after next vsync edge.
- Reset asserted while pending = 1 with 3'b101 -> pending = 0, color = 3'b111, subsequent vsync edge leaves color = 3'b111.
- RGB_AUTO_CYCLE_EN, AUTO_FRAMES = 2: commit 3'b000 -> color sequence 000, 001 after 2 frames, 010 after 4, ..., 111 -> 001; press with sw = 3'b011 -> auto-cycle stops at 3'b011.
